mac_2x2_unit: RTL
=================

# mac_2x2_unit

Sequential 2x2 block multiply-accumulate engine sitting directly downstream of the matrix-multiply control unit. It consumes one pair of 2x2 operand blocks (A, B) per `start_mac` pulse and accumulates C += A·B using a single shared signed multiplier. It returns the running 2x2 result on `c_11..c_22` with a one-cycle `done_mac` pulse. The control unit issues one start per k-step and clears the accumulator at the first k-step of each output block.

## Interface
- `data_w`, 32, element width (signed two's complement) for all a/b/c ports
- `clk` input 1, rising-edge clock
- `rst` input 1, asynchronous, active-low reset
- `start_mac` input 1, start one block MAC; sampled only in IDLE
- `acc_clr` input 1, sampled with `start_mac`; 1 = zero the accumulators before this block
- `a_11, a_12, a_21, a_22` input data_w, A block; sampled on the start edge
- `b_11, b_12, b_21, b_22` input data_w, B block; sampled on the start edge
- `c_11, c_12, c_21, c_22` output data_w, accumulator registers
- `done_mac` output 1, one-cycle pulse when C is final for this block
- `busy` output 1, high from the cycle after the start edge until `done_mac` falls
- `ovf` output 1, sticky overflow flag (see Configuration)

## Operation
- States:
  - IDLE: `start_mac`=1 latches all eight operands and applies `acc_clr`, then goes to MUL with idx=0.
  - MUL: one product per cycle, idx 0..7; after idx 7, go to DONE.
  - DONE: `done_mac`=1 for one cycle, then go to IDLE.
- Product schedule by idx:
  - 0: a11·b11→c11; 1: a12·b21→c11
  - 2: a11·b12→c12; 3: a12·b22→c12
  - 4: a21·b11→c21; 5: a22·b21→c21
  - 6: a21·b12→c22; 7: a22·b22→c22
- Arithmetic: full 2·data_w signed product. Default accumulation adds the low data_w bits of the product, wrapping mod 2^data_w.
- `acc_clr`=1 with start: all four accumulators and `ovf` are zeroed on the start edge; idx-0 accumulation then starts from 0.
- `start_mac` in MUL or DONE: ignored, with no queuing. Operand port changes after the start edge have no effect.
- The c outputs change during MUL. They are valid only while `done_mac`=1 and afterwards in IDLE until the next start.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE, idx 0, `c_*`=0, `done_mac`=0, `busy`=0, `ovf`=0, operand latches 0. Reset asserted mid-MUL aborts immediately; no `done_mac` is produced.
- Start sampled at edge E0. Accumulations occur at edges E1..E8 and `done_mac` is high between E9 and E10. Start-to-done latency is 9 cycles.
- `busy` rises after E0 and falls after E10, together with `done_mac`.
- Back-to-back: a start sampled at E10 (IDLE) is accepted, so sustained throughput is 1 block per 10 cycles.

## Configuration
- `MAC2X2_SATURATE_EN` defined:
  - Each accumulation computes acc + full product at 2·data_w+1 bits.
  - The sum clamps to [−2^(data_w−1), 2^(data_w−1)−1].
  - Any clamp sets `ovf`, which stays set until reset or a start with `acc_clr`.
- Not defined: wrapping accumulation as above; `ovf` is tied 0.

## Structure
- Package `mac_2x2_pkg`:
  - state enum (IDLE, MUL, DONE)
  - `MAC_PRODUCTS`=8
  - idx→(a row, k, b col) schedule constants
- Sub-module `mac_sat_add`: signed accumulator adder taking acc and product and returning the next acc plus an overflow bit. It implements the wrap or clamp behaviour under `MAC2X2_SATURATE_EN`.

## Test plan
- Reset then single block: A=[1 2;3 4], B=[5 6;7 8], `acc_clr`=1 → after 9 cycles `done_mac` pulses once with C=[19 22;43 50]; `busy` high for exactly 10 cycles.
- Accumulation: repeat the same A,B with `acc_clr`=0 → C=[38 44;86 100]. Then start with `acc_clr`=1, A=identity, B=[9 −1;−2 3] → C=[9 −1;−2 3].
- Signed operands: A=[−1 0;0 −1], B=[−5 7;2 −3], clear → C=[5 −7;−2 3].
- Start ignored: pulse `start_mac` at cycles 3 and 9 after an accepted start → exactly one `done_mac`, and C is unchanged by the ignored pulses.
- Overflow, data_w=32, a_11=b_11=2^16, others 0, clear, then repeat twice:
  - without macro: c_11 wraps to 0, `ovf`=0
  - with `MAC2X2_SATURATE_EN`: c_11=2^31−1, `ovf`=1, and it stays set until the next `acc_clr` start
- Reset mid-operation: assert `rst`=0 at cycle 4 of MUL → outputs 0 immediately, no `done_mac`. A new start after release behaves like the first test.

Source files
------------

// File: rtl/mac_2x2_pkg.sv
// mac_2x2_pkg: shared types and product schedule for the 2x2 block MAC engine.
package mac_2x2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    localparam int unsigned MAC_PRODUCTS = 8;
    localparam logic [2:0]  IdxLast      = 3'(MAC_PRODUCTS - 1);

    // Bit i of each mask gives the A row, inner k and B column used by product idx i.
    // Element index of a 2x2 block is {row, col}: 0=x11, 1=x12, 2=x21, 3=x22.
    localparam logic [MAC_PRODUCTS-1:0] SchedARow = 8'b1111_0000;
    localparam logic [MAC_PRODUCTS-1:0] SchedK    = 8'b1010_1010;
    localparam logic [MAC_PRODUCTS-1:0] SchedBCol = 8'b1100_1100;

    function automatic logic [1:0] elem_idx(logic row, logic col);
        return {row, col};
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: accumulator adder, acc + signed product -> next acc plus overflow bit.
// Build macro MAC2X2_SATURATE_EN: clamp to the signed DataW range and flag clamps;
// otherwise wrap modulo 2^DataW and never flag.
module mac_sat_add #(
    parameter int unsigned DataW = 32
) (
    input  logic [DataW-1:0]   acc_i,
    input  logic [2*DataW-1:0] prod_i,
    output logic [DataW-1:0]   sum_o,
    output logic               ovf_o
);

`ifdef MAC2X2_SATURATE_EN
    localparam int unsigned SumW = 2 * DataW + 1;

    logic [SumW-1:0]  sum_full;
    logic [DataW+1:0] sum_hi;

    // Exact sum, then clamp when the bits above the DataW sign bit disagree with it.
    always_comb begin
        sum_full = {{(DataW + 1){acc_i[DataW-1]}}, acc_i} + {prod_i[2*DataW-1], prod_i};
        sum_hi   = sum_full[SumW-1:DataW-1];
        ovf_o    = !((&sum_hi) || !(|sum_hi));
        if (!ovf_o) begin
            sum_o = sum_full[DataW-1:0];
        end else if (sum_full[SumW-1]) begin
            sum_o = {1'b1, {(DataW - 1){1'b0}}};
        end else begin
            sum_o = {1'b0, {(DataW - 1){1'b1}}};
        end
    end
`else
    logic unused_prod_hi;

    // Wrapping accumulation only needs the low half of the product.
    always_comb begin
        sum_o          = acc_i + prod_i[DataW-1:0];
        ovf_o          = 1'b0;
        unused_prod_hi = ^prod_i[2*DataW-1:DataW];
    end
`endif

endmodule

// File: rtl/mac_2x2_unit.sv
// mac_2x2_unit: sequential 2x2 block MAC, C += A*B with one shared signed multiplier,
// one product per cycle (8 cycles), done_mac pulse 9 cycles after the start edge.
// Build macro MAC2X2_SATURATE_EN: saturating accumulation with sticky ovf; default wraps.
module mac_2x2_unit
    import mac_2x2_pkg::*;
#(
    parameter int unsigned DataW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mac,
    input  logic             acc_clr,
    input  logic [DataW-1:0] a_11,
    input  logic [DataW-1:0] a_12,
    input  logic [DataW-1:0] a_21,
    input  logic [DataW-1:0] a_22,
    input  logic [DataW-1:0] b_11,
    input  logic [DataW-1:0] b_12,
    input  logic [DataW-1:0] b_21,
    input  logic [DataW-1:0] b_22,
    output logic [DataW-1:0] c_11,
    output logic [DataW-1:0] c_12,
    output logic [DataW-1:0] c_21,
    output logic [DataW-1:0] c_22,
    output logic             done_mac,
    output logic             busy,
    output logic             ovf
);

    state_e             state_q;
    logic [2:0]         idx_q;
    logic               done_q;
    logic               busy_q;
    logic [DataW-1:0]   a_q [4];
    logic [DataW-1:0]   b_q [4];
    logic [DataW-1:0]   c_q [4];

    logic [1:0]         a_sel;
    logic [1:0]         b_sel;
    logic [1:0]         c_sel;
    logic [DataW-1:0]   a_op;
    logic [DataW-1:0]   b_op;
    logic [DataW-1:0]   sum;
    logic [2*DataW-1:0] prod;
    logic               sat_ovf;

    // Decode the schedule step into operand and accumulator selects.
    always_comb begin
        a_sel = {SchedARow[idx_q], SchedK[idx_q]};
        b_sel = {SchedK[idx_q], SchedBCol[idx_q]};
        c_sel = elem_idx(SchedARow[idx_q], SchedBCol[idx_q]);
        a_op  = a_q[a_sel];
        b_op  = b_q[b_sel];
    end

    // Sign-extending both operands to 2*DataW makes the unsigned product the signed one.
    assign prod = {{DataW{a_op[DataW-1]}}, a_op} * {{DataW{b_op[DataW-1]}}, b_op};

    mac_sat_add #(
        .DataW (DataW)
    ) u_add (
        .acc_i  (c_q[c_sel]),
        .prod_i (prod),
        .sum_o  (sum),
        .ovf_o  (sat_ovf)
    );

    // Control FSM with registered done/busy; operand latches and accumulators live here too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_mac) begin
                        a_q[0]  <= a_11;
                        a_q[1]  <= a_12;
                        a_q[2]  <= a_21;
                        a_q[3]  <= a_22;
                        b_q[0]  <= b_11;
                        b_q[1]  <= b_12;
                        b_q[2]  <= b_21;
                        b_q[3]  <= b_22;
                        if (acc_clr) begin
                            for (int i = 0; i < 4; i++) begin
                                c_q[i] <= '0;
                            end
                        end
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= StMul;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                StMul: begin
                    c_q[c_sel] <= sum;
                    idx_q      <= idx_q + 3'd1;
                    if (idx_q == IdxLast) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // done_mac shows up in the following IDLE cycle, where a new start is legal.
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef MAC2X2_SATURATE_EN
    logic ovf_q;

    // Sticky clamp flag; only reset or a clearing start drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StIdle && start_mac && acc_clr) begin
            ovf_q <= 1'b0;
        end else if (state_q == StMul && sat_ovf) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_sat_ovf;
    assign unused_sat_ovf = sat_ovf;
    assign ovf            = 1'b0;
`endif

    assign c_11     = c_q[0];
    assign c_12     = c_q[1];
    assign c_21     = c_q[2];
    assign c_22     = c_q[3];
    assign done_mac = done_q;
    assign busy     = busy_q;

endmodule
